// File: rtl/dram_arbiter.sv
// Round-robin arbiter that shares a single registered-read DRAM port among NUM_C requesters.
// One transaction at a time: IDLE -> ISSUE -> (CAPTURE for reads) -> ACK -> IDLE.
module dram_arbiter #(
    parameter  int NUM_C = 4,
    parameter  int AW    = 16,
    parameter  int DW    = 16,
    localparam int IW    = (NUM_C > 1) ? $clog2(NUM_C) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_C-1:0]    req,
    input  logic [NUM_C-1:0]    we,
    input  logic [NUM_C*AW-1:0] addr,
    input  logic [NUM_C*DW-1:0] wdata,
    output logic [NUM_C-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic                busy,
    output logic [IW-1:0]       gnt_id,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   last_gnt;
    logic [IW-1:0]   winner;
    logic            found;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        winner    = last_gnt;
        found     = 1'b0;

        // Search starts just after the last winner and wraps, giving requester last_gnt lowest priority.
        for (int k = 1; k <= NUM_C; k++) begin
            if (!found && req[(int'(last_gnt) + k) % NUM_C]) begin
                found  = 1'b1;
                winner = IW'((int'(last_gnt) + k) % NUM_C);
            end
        end

        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            // mem_we carries the latched direction while in ISSUE.
            ISSUE:   state_nxt = mem_we ? ACK : CAPTURE;
            CAPTURE: state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_gnt  <= IW'(NUM_C - 1);
            gnt_id    <= '0;
            ack       <= '0;
            rdata     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_nxt;
            ack    <= '0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        last_gnt  <= winner;
                        gnt_id    <= winner;
                        mem_we    <= we[winner];
                        mem_addr  <= addr[int'(winner)*AW +: AW];
                        mem_wdata <= wdata[int'(winner)*DW +: DW];
                    end
                end
                ISSUE: begin
                    if (mem_we) ack <= NUM_C'(1) << gnt_id;
                end
                CAPTURE: begin
                    rdata <= mem_rdata;
                    ack   <= NUM_C'(1) << gnt_id;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter: NUM_C, default 4, number of requester ports sharing one DRAM port.
REQ-002 Parameter: AW, default 16, address width; DW, default 16, data width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  NUM_C  per-requester transaction request, level.
REQ-006 we  input  NUM_C  per-requester write enable (1 write, 0 read).
REQ-007 addr  input  NUM_C*AW  packed addresses, requester i at bits [i*AW +: AW].
REQ-008 wdata  input  NUM_C*DW  packed write data, requester i at bits [i*DW +: DW].
REQ-009 ack  output  NUM_C  one-hot, one-cycle completion pulse to the granted requester.
REQ-010 rdata  output  DW  registered read data, shared by all requesters.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 gnt_id  output  clog2(NUM_C)  index of the current/last granted requester.
REQ-013 mem_we  output  1  DRAM port write enable.
REQ-014 mem_addr  output  AW  DRAM port address.
REQ-015 mem_wdata  output  DW  DRAM port write data.
REQ-016 mem_rdata  input  DW  DRAM port read data; registered in DRAM, valid the cycle after the address is sampled.

Function
REQ-017 FSM states: IDLE, ISSUE, CAPTURE, ACK; all outputs registered.
REQ-018 IDLE: with req nonzero, select winner round-robin; latch we, addr, wdata of winner; gnt_id <= winner; go ISSUE. With req zero, stay IDLE.
REQ-019 Round-robin: search starts at (last_gnt+1) mod NUM_C, upward with wrap; last_gnt updates only on grant.
REQ-020 req is sampled only in IDLE; requests in other states wait, none dropped while held.
REQ-021 ISSUE: mem_we = latched we for exactly one cycle; mem_addr/mem_wdata = latched values; write -> ACK, read -> CAPTURE.
REQ-022 mem_we is 0 in every state except ISSUE; mem_addr/mem_wdata hold last latched values outside ISSUE.
REQ-023 CAPTURE: rdata <= mem_rdata at end of cycle; go ACK.
REQ-024 ACK: ack[gnt_id] = 1 for exactly one cycle, other ack bits 0; go IDLE.
REQ-025 Latency from IDLE cycle sampling req (cycle 0): write ack in cycle 2, read ack in cycle 3 with rdata valid in the same cycle.
REQ-026 rdata holds its value until the next read CAPTURE; writes do not alter it.
REQ-027 Requester holds we/addr/wdata stable while req high; the arbiter uses only values latched in IDLE.
REQ-028 req dropped after grant: transaction still completes and ack still pulses.
REQ-029 req held high through ack: treated as a new request at the next IDLE, round-robin order applies.
REQ-030 Simultaneous requests: exactly one grant per transaction, never two ack bits in one cycle.
REQ-031 Minimum spacing between grants: 3 cycles (write) or 4 cycles (read); every continuously-requesting port is served within NUM_C transactions.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, ack 0, rdata 0, busy 0, gnt_id 0, mem_we 0, mem_addr 0, mem_wdata 0, last_gnt NUM_C-1 (requester 0 has first priority).
REQ-033 Reset mid-transaction aborts it: no ack issued, mem_we deasserted immediately; an aborted ISSUE write is not guaranteed to reach DRAM.
REQ-034 First grant possible in the first clk edge after rst_n deasserts.

Verification
REQ-035 Single write: req[2]=1, we[2]=1, addr=0x0010, wdata=0x00AB -> mem_we=1 with mem_addr=0x0010, mem_wdata=0x00AB for one cycle; ack=4'b0100 in cycle 2.
REQ-036 Read-back: after REQ-035, req[1] read addr 0x0010 -> ack=4'b0010 in cycle 3, rdata=0x00AB.
REQ-037 Fairness: req=4'b1111 held, all reads -> ack sequence 0,1,2,3,0 by index, one ack per 4 cycles, never two ack bits.
REQ-038 Wrap priority: last grant 3, then req=4'b1001 -> grant 0, next grant 3.
REQ-039 Withdrawn request: req[0] pulsed for only the IDLE cycle, write -> write still issued, ack[0] pulses in cycle 2.
REQ-040 Reset abort: rst_n low during CAPTURE -> ack stays 0, busy=0, mem_we=0, rdata=0; after release req[3] granted first only if req[0..2] low.
